// File: rtl/sound_event_issuer.sv
// Turns raw game event levels into paced, fixed-length tone requests for the sound engine.
// Rising edges are queued in a small FIFO and replayed as tone + silent gap, with mute and drop counting.
module sound_event_issuer #(
  parameter int DEPTH       = 4,
  parameter int TONE_CYCLES = 50,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       good_evt,
  input  logic       bad_evt,
  input  logic [3:0] dir_evt,
  input  logic       mute_toggle,
  output logic       goodColl,
  output logic       badColl,
  output logic [3:0] direction,
  output logic       busy,
  output logic       full,
  output logic       muted,
  output logic [3:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TONE_CYCLES + GAP_CYCLES + 1);

  localparam logic [1:0] CODE_GOOD = 2'b01;
  localparam logic [1:0] CODE_BAD  = 2'b10;
  localparam logic [1:0] CODE_DIR  = 2'b11;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Valid/ready note: the edge detector offers at most one entry per cycle; the FIFO
  // accepts it when not full or when the FSM pops in the same cycle, otherwise it is dropped.

  logic       prev_good, prev_bad, prev_mute;
  logic [3:0] prev_dir;
  logic       muted_q;

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [3:0]    drop_q;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          good_q, bad_q;
  logic [3:0]    dir_q;

  logic       good_rise, bad_rise, mute_rise, mute_enter;
  logic [3:0] dir_rise;
  logic       push_req, do_push, drop_inc, pop, clr, fifo_full, fifo_empty;
  logic [5:0] push_data, head;

  assign good_rise  = good_evt & ~prev_good;
  assign bad_rise   = bad_evt & ~prev_bad;
  assign dir_rise   = dir_evt & ~prev_dir;
  assign mute_rise  = mute_toggle & ~prev_mute;
  assign mute_enter = mute_rise & ~muted_q;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  // Priority bad > good > dir; nothing is offered while muted or on the cycle mute flips.
  always_comb begin
    push_req  = 1'b0;
    push_data = 6'b0;
    if (bad_rise) begin
      push_req  = 1'b1;
      push_data = {CODE_BAD, 4'b0};
    end else if (good_rise) begin
      push_req  = 1'b1;
      push_data = {CODE_GOOD, 4'b0};
    end else if (|dir_rise) begin
      push_req  = 1'b1;
      push_data = {CODE_DIR, dir_rise};
    end
    if (muted_q || mute_rise) push_req = 1'b0;
  end

  assign do_push  = push_req & (~fifo_full | pop);
  assign drop_inc = push_req & fifo_full & ~pop;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = PLAY;
          timer_d = TW'(TONE_CYCLES - 1);
        end
      end
      PLAY: begin
        if (timer_q == '0) begin
          clr     = 1'b1;
          state_d = GAP;
          timer_d = TW'(GAP_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = PLAY;
            timer_d = TW'(TONE_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      prev_good <= 1'b0;
      prev_bad  <= 1'b0;
      prev_dir  <= 4'b0;
      prev_mute <= 1'b0;
      muted_q   <= 1'b0;
    end else begin
      prev_good <= good_evt;
      prev_bad  <= bad_evt;
      prev_dir  <= dir_evt;
      prev_mute <= mute_toggle;
      if (mute_rise) muted_q <= ~muted_q;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop_q <= 4'd0;
    end else if (mute_enter) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop) count <= count + CW'(1);
      else if (pop && !do_push) count <= count - CW'(1);
      if (drop_inc && drop_q != 4'hF) drop_q <= drop_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst || mute_enter) begin
      state_q <= IDLE;
      timer_q <= '0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      dir_q   <= 4'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (pop) begin
        good_q <= (head[5:4] == CODE_GOOD);
        bad_q  <= (head[5:4] == CODE_BAD);
        dir_q  <= (head[5:4] == CODE_DIR) ? head[3:0] : 4'b0;
      end else if (clr) begin
        good_q <= 1'b0;
        bad_q  <= 1'b0;
        dir_q  <= 4'b0;
      end
    end
  end

  assign goodColl   = good_q;
  assign badColl    = bad_q;
  assign direction  = dir_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  assign full       = fifo_full;
  assign muted      = muted_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_sound_event_issuer.sv
// Directed bench for sound_event_issuer: table of {inputs, cycles, expected outputs} plus
// hand-written overflow, reset-mid-tone and mute sequences.
module tb_sound_event_issuer;

  logic       clk = 1'b0;
  logic       nRst;
  logic       good_evt, bad_evt, mute_toggle;
  logic [3:0] dir_evt;
  logic       goodColl, badColl, busy, full, muted;
  logic [3:0] direction, drop_count;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int          cyc;
    logic        nrst;
    logic        good;
    logic        bad;
    logic [3:0]  dir;
    logic        mute;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  sound_event_issuer #(.DEPTH(4), .TONE_CYCLES(50), .GAP_CYCLES(2)) dut (
    .clk(clk), .nRst(nRst), .good_evt(good_evt), .bad_evt(bad_evt), .dir_evt(dir_evt),
    .mute_toggle(mute_toggle), .goodColl(goodColl), .badColl(badColl), .direction(direction),
    .busy(busy), .full(full), .muted(muted), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(logic g, logic b, logic [3:0] d, logic bz,
                                     logic fl, logic mu, logic [3:0] dr);
    return {g, b, d, bz, fl, mu, dr};
  endfunction

  task automatic add(int cyc, logic nrst, logic g, logic b, logic [3:0] d, logic m,
                     logic [12:0] exp);
    vec_t v;
    v.cyc = cyc; v.nrst = nrst; v.good = g; v.bad = b; v.dir = d; v.mute = m; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Drive inputs, advance cyc posedges, then settle 1 time unit past the last edge.
  task automatic apply(logic nrst, logic g, logic b, logic [3:0] d, logic m, int cyc);
    nRst = nrst; good_evt = g; bad_evt = b; dir_evt = d; mute_toggle = m;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string name, logic [12:0] exp);
    logic [12:0] act;
    act = {goodColl, badColl, direction, busy, full, muted, drop_count};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h (fields good,bad,dir,busy,full,muted,drop)",
               name, act, exp);
    end
  endtask

  initial begin
    nRst = 1'b0; good_evt = 1'b0; bad_evt = 1'b0; dir_evt = 4'b0; mute_toggle = 1'b0;

    // reset, single good pulse and its exact tone window
    add(2,   0, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0));
    add(1,   1, 1, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(1, 0, 4'h0, 1, 0, 0, 0));
    add(49,  1, 0, 0, 4'h0, 0, mk(1, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(2,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0));
    // held good level for 200 cycles yields one tone
    add(1,   1, 1, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 1, 0, 4'h0, 0, mk(1, 0, 4'h0, 1, 0, 0, 0));
    add(52,  1, 1, 0, 4'h0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0));
    add(146, 1, 1, 0, 4'h0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0));
    // bad and dir rising together: only bad is queued
    add(1,   1, 0, 1, 4'h2, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 1, 4'h0, 1, 0, 0, 0));
    add(50,  1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(2,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0));
    // bad, good, dir on consecutive cycles: ordered tones, 2-cycle gaps
    add(1,   1, 0, 1, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 1, 0, 4'h0, 0, mk(0, 1, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h8, 0, mk(0, 1, 4'h0, 1, 0, 0, 0));
    add(48,  1, 0, 0, 4'h0, 0, mk(0, 1, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(1, 0, 4'h0, 1, 0, 0, 0));
    add(49,  1, 0, 0, 4'h0, 0, mk(1, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h8, 1, 0, 0, 0));
    add(49,  1, 0, 0, 4'h0, 0, mk(0, 0, 4'h8, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(2,   1, 0, 0, 4'h0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0));
    // start a tone for the overflow sequence
    add(1,   1, 1, 0, 4'h0, 0, mk(0, 0, 4'h0, 1, 0, 0, 0));
    add(1,   1, 0, 0, 4'h0, 0, mk(1, 0, 4'h0, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].nrst, tbl[i].good, tbl[i].bad, tbl[i].dir, tbl[i].mute, tbl[i].cyc);
      expect_out($sformatf("vec%0d", i), tbl[i].exp);
    end

    // overflow: one event per cycle (bad/good alternate) while the tone holds the FSM
    for (int j = 0; j < 6; j++) apply(1, (j % 2) == 1, (j % 2) == 0, 4'h0, 0, 1);
    expect_out("ovf_first6", mk(1, 0, 4'h0, 1, 1, 0, 4'd2));
    for (int j = 6; j < 26; j++) apply(1, (j % 2) == 1, (j % 2) == 0, 4'h0, 0, 1);
    expect_out("ovf_saturate", mk(1, 0, 4'h0, 1, 1, 0, 4'd15));
    apply(1, 0, 0, 4'h0, 0, 24);
    expect_out("ovf_tone_end", mk(0, 0, 4'h0, 1, 1, 0, 4'd15));
    apply(1, 0, 0, 4'h0, 0, 2);
    expect_out("ovf_head_bad", mk(0, 1, 4'h0, 1, 0, 0, 4'd15));

    // synchronous reset in the middle of a tone
    apply(0, 0, 0, 4'h0, 0, 1);
    expect_out("reset_mid_tone", mk(0, 0, 4'h0, 0, 0, 0, 4'd0));

    // mute: flush while playing with two queued, ignore events, unmute without replay
    apply(1, 1, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 4'h0, 0, 1);
    expect_out("mute_pre_tone", mk(1, 0, 4'h0, 1, 0, 0, 0));
    apply(1, 0, 1, 4'h0, 0, 1);
    apply(1, 1, 0, 4'h0, 0, 1);
    expect_out("mute_queued", mk(1, 0, 4'h0, 1, 0, 0, 0));
    apply(1, 0, 0, 4'h0, 1, 1);
    expect_out("mute_enter", mk(0, 0, 4'h0, 0, 0, 1, 0));
    apply(1, 0, 1, 4'h0, 0, 1);
    apply(1, 0, 0, 4'h0, 0, 3);
    expect_out("muted_event", mk(0, 0, 4'h0, 0, 0, 1, 0));
    apply(1, 0, 0, 4'h0, 1, 1);
    expect_out("unmute", mk(0, 0, 4'h0, 0, 0, 0, 0));
    apply(1, 0, 0, 4'h0, 0, 3);
    expect_out("no_replay", mk(0, 0, 4'h0, 0, 0, 0, 0));
    apply(1, 1, 0, 4'h0, 0, 1);
    apply(1, 0, 0, 4'h0, 0, 1);
    expect_out("post_unmute_tone", mk(1, 0, 4'h0, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sound_event_issuer.md
# sound_event_issuer

Game-side initiator for the sound path: turns raw game event strobes (food eaten, wall/self hit, direction change) into clean, paced request levels on the goodColl / badColl / direction lines consumed by the sound engine. Rising edges are detected internally and queued in a small FIFO. Each queued event is replayed as a fixed-length tone request followed by a silent gap, so back-to-back events become distinct, audible tones. The block also provides a mute toggle and a saturating drop counter.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- TONE_CYCLES, 50, cycles each request is held high (0.5 s at 100 Hz)
- GAP_CYCLES, 2, cycles of all-low outputs between requests (≥1)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock (hz100)
- nRst  in  1  synchronous active-low reset, sampled on posedge clk
- good_evt  in  1  food-eaten event, level from game logic
- bad_evt  in  1  collision event, level
- dir_evt  in  4  direction-change event bits {up, down, left, right}
- mute_toggle  in  1  mute button, level; each rising edge toggles mute
- goodColl  out  1  request: good tone
- badColl  out  1  request: bad tone
- direction  out  4  request: direction tone (replayed dir bits)
- busy  out  1  FSM not IDLE or FIFO non-empty
- full  out  1  FIFO holds DEPTH entries
- muted  out  1  current mute state
- drop_count  out  4  saturating count of events lost to a full FIFO

## Operation
- Edge detect: registers prev_good, prev_bad, prev_dir[3:0], prev_mute. An event fires on a cycle where the input is 1 and its prev register is 0. A held level fires once.
- Event selection: at most one push per cycle, with priority bad > good > dir.
  - A dir event fires when any dir bit has a rising edge. The stored vector is dir_evt & ~prev_dir.
  - Lower-priority events that fire in the same cycle are discarded and not counted.
- Entry format: 6 bits {code[1:0], dir[3:0]}. Codes: 01 good, 10 bad, 11 dir.
- FIFO: circular, with read/write pointers plus a count. Pointers wrap modulo DEPTH.
  - A push while full (with no pop that cycle) is dropped, and drop_count increments, saturating at 15.
  - Push and pop in the same cycle while full are both accepted, and count is unchanged.
  - Push and pop in the same cycle while empty: the entry is not bypassed. The pop sees empty and the push is stored.
- FSM states: IDLE, PLAY, GAP.
  - IDLE → PLAY when the FIFO is non-empty. This pops the head, loads the output registers from it, and sets the timer to TONE_CYCLES-1.
  - PLAY: exactly one output field is driven, per code. The timer decrements; at 0, go to GAP, clear outputs, and set the timer to GAP_CYCLES-1.
  - GAP: timer decrements; at 0, go to PLAY with a pop if the FIFO is non-empty, otherwise go to IDLE.
- Mute:
  - A rising edge of mute_toggle flips muted.
  - Entering mute flushes the FIFO, forces IDLE, and clears outputs on the same edge.
  - While muted, no pushes occur and drop_count is unchanged.
  - Unmuting does not replay anything.
- Outputs goodColl, badColl and direction are registered; they are never combinational from the inputs.

## Timing
- Reset (nRst=0 at a posedge) clears, on that edge:
  - all outputs to 0 and muted to 0;
  - drop_count to 0, the FIFO to empty, and the FSM to IDLE;
  - all prev registers to 0.
- Because reset is synchronous, any in-progress tone is cut on that edge, and the FIFO contents are lost.
- Latency with FSM in IDLE and FIFO empty:
  - edge k: input sampled 1 with prev 0, entry written;
  - edge k+1: pop, and the output goes high after this edge;
  - the output is high for exactly TONE_CYCLES cycles and falls after edge k+1+TONE_CYCLES.
- Back-to-back queued events: the next request rises exactly GAP_CYCLES cycles after the previous one falls.
- full and busy reflect state after the current edge (registered count).

## Test plan
- Reset: assert nRst=0 for 1 cycle mid-tone → all outputs 0, busy=0, drop_count=0, muted=0 on the next cycle.
- Single event: good_evt pulsed high for 1 cycle at edge 10 → goodColl high from after edge 11 through edge 61 (50 cycles), then low. badColl and direction stay 0.
- Held level plus simultaneous events: good_evt held high for 200 cycles → exactly one tone. bad_evt and dir_evt=4'b0010 rising on the same cycle → only a badColl tone, with no direction tone.
- Queue pacing: 3 events (bad, good, dir=4'b1000) on consecutive cycles → tones play in order, each 50 cycles long, separated by exactly 2 low cycles. direction=4'b1000 during the third tone.
- Overflow: with a tone playing, fire 6 distinct events → FIFO keeps the first 4, full=1, drop_count=2. Then 20 further events while full → drop_count=15 (saturated).
- Mute: with a tone playing and 2 events queued, pulse mute_toggle → outputs 0 next cycle, muted=1, FIFO empty. An event while muted → no tone and drop_count unchanged. A second toggle → muted=0, and a new event plays normally.
